// File: rtl/servo_pkg.sv
// ============================================================================
// Module      : servo_pkg
// Description : Shared constants, register map and types for the servo path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servo_pkg;

  // Frame length and neutral width are shared with the PWM stage.
  localparam int unsigned c_period        = 2000000;
  localparam int unsigned c_default_width = 150000;
  localparam int unsigned c_default_min   = 100000;
  localparam int unsigned c_default_max   = 200000;
  localparam int unsigned c_default_step  = 1000;

  localparam logic [2:0] c_reg_target = 3'd0;
  localparam logic [2:0] c_reg_step   = 3'd1;
  localparam logic [2:0] c_reg_min    = 3'd2;
  localparam logic [2:0] c_reg_max    = 3'd3;
  localparam logic [2:0] c_reg_status = 3'd4;
  localparam logic [2:0] c_reg_width  = 3'd5;

  localparam int unsigned c_bit_settled = 0;
  localparam int unsigned c_bit_clamped = 1;
  localparam int unsigned c_bit_cfg_err = 2;

  typedef enum logic [1:0] {
    ST_SETTLED   = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } ramp_state_t;

  function automatic logic [31:0] clamp_width(input logic [31:0] t,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] v;
    v = (t < lo) ? lo : t;
    return (v > hi) ? hi : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/servo_frame_timer.sv
// ============================================================================
// Module      : servo_frame_timer
// Description : Free-running PERIOD counter; o_tick marks the last frame cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD = c_period
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] c_last = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/servo_ramp.sv
// ============================================================================
// Module      : servo_ramp
// Description : APB3 slave slewing the PWM pulse width toward a clamped target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD        = c_period,
  parameter int unsigned DEFAULT_WIDTH = c_default_width,
  parameter int unsigned DEFAULT_MIN   = c_default_min,
  parameter int unsigned DEFAULT_MAX   = c_default_max,
  parameter int unsigned DEFAULT_STEP  = c_default_step
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] pulse_width,
  output logic        width_update,
  output logic        settled
);

  logic [31:0] r_target, r_step, r_min, r_max, r_width;
  logic        r_clamped, r_update;
  ramp_state_t r_state, w_state_nxt;

  logic        w_tick, w_wr, w_cfg_err, w_up;
  logic [2:0]  w_sel;
  logic [31:0] w_ct, w_diff, w_width_nxt;
  logic        w_unused;

  servo_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (PCLK),
    .rst_n  (PRESERN),
    .o_tick (w_tick)
  );

  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_sel     = PADDR[4:2];
  assign w_unused  = ^{PADDR[31:5], PADDR[1:0]};
  assign w_cfg_err = (r_min > r_max);
  assign w_ct      = clamp_width(r_target, r_min, r_max);

  // Magnitude by compare-then-subtract keeps everything unsigned and wrap-free.
  assign w_up   = (r_width < w_ct);
  assign w_diff = w_up ? (w_ct - r_width) : (r_width - w_ct);

  always_comb begin
    w_width_nxt = w_ct;
    if ((r_step != '0) && (w_diff > r_step)) begin
      w_width_nxt = w_up ? (r_width + r_step) : (r_width - r_step);
    end
  end

  always_comb begin
    w_state_nxt = ST_SETTLED;
    if (r_width < w_ct) begin
      w_state_nxt = ST_RAMP_UP;
    end else if (r_width > w_ct) begin
      w_state_nxt = ST_RAMP_DOWN;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state <= ST_SETTLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_target  <= DEFAULT_WIDTH;
      r_step    <= DEFAULT_STEP;
      r_min     <= DEFAULT_MIN;
      r_max     <= DEFAULT_MAX;
      r_width   <= DEFAULT_WIDTH;
      r_clamped <= 1'b0;
      r_update  <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_wr) begin
        case (w_sel)
          c_reg_target: r_target <= PWDATA;
          c_reg_step:   r_step   <= PWDATA;
          c_reg_min:    r_min    <= PWDATA;
          c_reg_max:    r_max    <= PWDATA;
          c_reg_status: if (PWDATA[c_bit_clamped]) r_clamped <= 1'b0;
          default:      ;
        endcase
      end
      // A clamp seen on the same tick as a clear wins, so no event is lost.
      if (w_tick) begin
        if (w_ct != r_target) begin
          r_clamped <= 1'b1;
        end
        if (!w_cfg_err) begin
          r_width  <= w_width_nxt;
          r_update <= (w_width_nxt != r_width);
        end
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (w_sel)
        c_reg_target: PRDATA = r_target;
        c_reg_step:   PRDATA = r_step;
        c_reg_min:    PRDATA = r_min;
        c_reg_max:    PRDATA = r_max;
        c_reg_status: begin
          PRDATA[c_bit_settled] = (r_state == ST_SETTLED);
          PRDATA[c_bit_clamped] = r_clamped;
          PRDATA[c_bit_cfg_err] = w_cfg_err;
        end
        c_reg_width:  PRDATA = r_width;
        default:      PRDATA = '0;
      endcase
    end
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = 1'b0;
  assign pulse_width  = r_width;
  assign width_update = r_update;
  assign settled      = (r_state == ST_SETTLED);

endmodule

`default_nettype wire

// File: tb/tb_servo_ramp.sv
// ============================================================================
// Module      : tb_servo_ramp
// Description : Directed, table-driven bench for servo_ramp with a 100-cycle frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_ramp;

  localparam int unsigned c_per = 100;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA, pulse_width;
  logic        PREADY, PSLVERR, width_update, settled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_cnt = 0;

  servo_ramp #(.PERIOD(c_per)) dut (
    .PCLK         (PCLK),
    .PRESERN      (PRESERN),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .pulse_width  (pulse_width),
    .width_update (width_update),
    .settled      (settled)
  );

  always #5 PCLK = ~PCLK;

  // Reference cycle count since reset release; ticks land on multiples of c_per.
  always @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge PCLK) begin
    if (PRESERN && width_update) upd_cnt <= upd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    chk(name, d, exp);
  endtask

  task automatic to_after_tick();
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((cyc % c_per) != 0 && n < 3 * c_per);
    if ((cyc % c_per) != 0) begin
      errors++;
      $display("FAIL tick_wait: no frame boundary within %0d cycles", n);
    end
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((cyc % c_per) != ph && n < 3 * c_per);
  endtask

  task automatic do_reset(input string name);
    #2 PRESERN = 1'b0;
    #1 chk(name, pulse_width, 32'd150000);
    @(negedge PCLK);
    PRESERN = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rv[8];
  logic [31:0] ramp_exp[4];

  initial begin
    int base;

    rv[0] = '{"rst_target", 32'h00, 32'd150000};
    rv[1] = '{"rst_step",   32'h04, 32'd1000};
    rv[2] = '{"rst_min",    32'h08, 32'd100000};
    rv[3] = '{"rst_max",    32'h0C, 32'd200000};
    rv[4] = '{"rst_status", 32'h10, 32'h1};
    rv[5] = '{"rst_width",  32'h14, 32'd150000};
    rv[6] = '{"rsv_18",     32'h18, 32'h0};
    rv[7] = '{"rsv_1c",     32'h1C, 32'h0};
    ramp_exp[0] = 32'd151000; ramp_exp[1] = 32'd152000;
    ramp_exp[2] = 32'd153000; ramp_exp[3] = 32'd153500;

    repeat (3) @(negedge PCLK);
    chk("rst_pw", pulse_width, 32'd150000);
    chk("rst_settled", {31'b0, settled}, 32'd1);
    PRESERN = 1'b1;

    // Reset values through the register map.
    for (int i = 0; i < 8; i++) read_chk(rv[i].name, rv[i].addr, rv[i].exp);
    for (int i = 0; i < 2; i++) begin
      to_after_tick();
      chk("idle_upd", {31'b0, width_update}, 32'd0);
    end
    chk("idle_upd_cnt", upd_cnt, 32'd0);

    // Ramp up in 1000-count steps with a 500 remainder.
    apb_write(32'h00, 32'd153500);
    base = upd_cnt;
    for (int k = 0; k < 4; k++) begin
      to_after_tick();
      chk("ramp_pw", pulse_width, ramp_exp[k]);
      chk("ramp_upd", {31'b0, width_update}, 32'd1);
      repeat (2) @(negedge PCLK);
      chk("ramp_settled", {31'b0, settled}, (k == 3) ? 32'd1 : 32'd0);
    end
    read_chk("ramp_width_reg", 32'h14, 32'd153500);
    chk("ramp_upd_cnt", upd_cnt - base, 32'd4);

    // Immediate jump clamped to MAX; sticky clamp flag with W1C.
    apb_write(32'h04, 32'd0);
    apb_write(32'h00, 32'd250000);
    to_after_tick();
    chk("clamp_pw", pulse_width, 32'd200000);
    read_chk("clamp_status", 32'h10, 32'h3);
    apb_write(32'h10, 32'h2);
    read_chk("clamp_clr", 32'h10, 32'h1);
    to_after_tick();
    read_chk("clamp_reset", 32'h10, 32'h3);

    // Direction reversal mid-ramp.
    do_reset("rst_async_pw");
    apb_write(32'h00, 32'd160000);
    to_after_tick(); chk("rev_pw1", pulse_width, 32'd151000);
    to_after_tick(); chk("rev_pw2", pulse_width, 32'd152000);
    apb_write(32'h00, 32'd150500);
    to_after_tick(); chk("rev_pw3", pulse_width, 32'd151000);
    to_after_tick(); chk("rev_pw4", pulse_width, 32'd150500);
    read_chk("rev_status", 32'h10, 32'h1);

    // TARGET write landing on the tick edge uses the old TARGET there.
    wait_phase(c_per - 2);
    apb_write(32'h00, 32'd151000);
    chk("sim_phase", cyc % c_per, 32'd0);
    chk("sim_pw_hold", pulse_width, 32'd150500);
    chk("sim_upd_none", {31'b0, width_update}, 32'd0);
    to_after_tick();
    chk("sim_pw_next", pulse_width, 32'd151000);

    // MIN > MAX freezes the output.
    apb_write(32'h0C, 32'd170000);
    apb_write(32'h08, 32'd180000);
    read_chk("cfg_status", 32'h10, 32'h4);
    to_after_tick();
    chk("cfg_pw_frozen", pulse_width, 32'd151000);
    chk("cfg_upd_none", {31'b0, width_update}, 32'd0);
    read_chk("cfg_status_clamp", 32'h10, 32'h6);

    // Asynchronous reset mid-frame, then the frame counter restarts at 0.
    repeat (20) @(negedge PCLK);
    do_reset("rst_mid_pw");
    read_chk("post_rst_min", 32'h08, 32'd100000);
    apb_write(32'h00, 32'd151000);
    while (cyc < c_per - 1) @(negedge PCLK);
    chk("restart_pre", pulse_width, 32'd150000);
    @(negedge PCLK);
    chk("restart_pw", pulse_width, 32'd151000);
    chk("restart_upd", {31'b0, width_update}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
